// File: rtl/plot_framebuffer_pkg.sv
// Shared definitions for the plot interface: screen geometry, coordinate and
// address widths, framebuffer state encoding and the pixel-address helper.
package plot_framebuffer_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ADDR_W   = 15;
  localparam int PIXELS   = H_RES * V_RES;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

  // y*160 + x from two shifts and adds, so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = ADDR_W'(y);
    return (y_ext << 3'd7) + (y_ext << 3'd5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_framebuffer_fifo.sv
// Small synchronous FIFO of pending plot writes {x, y, colour}; flush empties it
// in one cycle.
module plot_fifo
  import plot_framebuffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  flush,
  input  logic  push,
  input  plot_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output plot_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  plot_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/plot_framebuffer.sv
// Plot sink: queues plot writes, commits them to a 160x120 pixel store between
// scanout reads, streams the store in raster order and clears it on request.
module plot_framebuffer
  import plot_framebuffer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_DIV    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                plot_in,
  input  logic                clear_in,
  output logic                busy,
  output logic                overflow,
  output logic [X_W-1:0]      scan_x,
  output logic [Y_W-1:0]      scan_y,
  output logic [COLOUR_W-1:0] scan_colour,
  output logic                scan_valid,
  output logic                frame_start
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(PIX_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIXELS - 1);
  localparam logic [X_W-1:0]    X_LAST     = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(V_RES - 1);

  fb_state_e           state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [X_W-1:0]      sx_q, sx_d;
  logic [Y_W-1:0]      sy_q, sy_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic                overflow_q, overflow_d;
  logic [X_W-1:0]      scan_x_q, scan_x_d;
  logic [Y_W-1:0]      scan_y_q, scan_y_d;
  logic                scan_valid_q, scan_valid_d;
  logic                frame_start_q, frame_start_d;
  logic [COLOUR_W-1:0] scan_colour_q;
  logic [COLOUR_W-1:0] store_q [PIXELS];

  logic                tick_s, run_s, in_range_s, clear_done_s;
  logic                fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic                rd_en_s, wr_en_s;
  logic [ADDR_W-1:0]   rd_addr_s, wr_addr_s;
  logic [COLOUR_W-1:0] wr_data_s;
  plot_t               push_data_s, head_s;

  assign tick_s       = (div_q == {DIV_W{1'b0}});
  assign run_s        = (state_q == ST_RUN) && !clear_in;
  assign in_range_s   = (x_in < X_W'(H_RES)) && (y_in < Y_W'(V_RES));
  assign clear_done_s = (state_q == ST_CLEAR) && !clear_in && (clr_q == LAST_ADDR);
  assign push_data_s  = {x_in, y_in, colour_in};
  assign push_s       = run_s && plot_in && in_range_s && !fifo_full_s;
  // The scanout read owns the store port on tick cycles; queued writes use the rest.
  assign rd_en_s      = run_s && tick_s;
  assign pop_s        = run_s && !tick_s && !fifo_empty_s;
  assign rd_addr_s    = pix_addr(sx_q, sy_q);

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (clear_in),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (head_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      div_q         <= DIV_RELOAD;
      sx_q          <= {X_W{1'b0}};
      sy_q          <= {Y_W{1'b0}};
      clr_q         <= {ADDR_W{1'b0}};
      overflow_q    <= 1'b0;
      scan_x_q      <= {X_W{1'b0}};
      scan_y_q      <= {Y_W{1'b0}};
      scan_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      scan_colour_q <= {COLOUR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      clr_q         <= clr_d;
      overflow_q    <= overflow_d;
      scan_x_q      <= scan_x_d;
      scan_y_q      <= scan_y_d;
      scan_valid_q  <= scan_valid_d;
      frame_start_q <= frame_start_d;
      if (rd_en_s) scan_colour_q <= store_q[rd_addr_s];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_s) store_q[wr_addr_s] <= wr_data_s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (clear_in) state_d = ST_CLEAR;
        else          state_d = ST_RUN;
      end
      ST_CLEAR: begin
        if (clear_in)          state_d = ST_CLEAR;
        else if (clear_done_s) state_d = ST_RUN;
        else                   state_d = ST_CLEAR;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    wr_en_s       = 1'b0;
    wr_addr_s     = {ADDR_W{1'b0}};
    wr_data_s     = {COLOUR_W{1'b0}};
    div_d         = div_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    clr_d         = clr_q;
    overflow_d    = overflow_q;
    scan_x_d      = scan_x_q;
    scan_y_d      = scan_y_q;
    scan_valid_d  = rd_en_s;
    frame_start_d = rd_en_s && (sx_q == {X_W{1'b0}}) && (sy_q == {Y_W{1'b0}});

    if (state_q == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_q;
      wr_data_s = {COLOUR_W{1'b0}};
    end else if (pop_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = pix_addr(head_s.x, head_s.y);
      wr_data_s = head_s.colour;
    end else begin
      wr_en_s   = 1'b0;
    end

    if (clear_done_s || tick_s) div_d = DIV_RELOAD;
    else                        div_d = div_q - 1'b1;

    if (clear_in)                   clr_d = {ADDR_W{1'b0}};
    else if (state_q == ST_CLEAR)   clr_d = clear_done_s ? {ADDR_W{1'b0}} : clr_q + 1'b1;
    else                            clr_d = clr_q;

    if (clear_in)                                         overflow_d = 1'b0;
    else if (run_s && plot_in && in_range_s && fifo_full_s) overflow_d = 1'b1;
    else                                                  overflow_d = overflow_q;

    // Raster counter: restarts at the origin when a clear finishes.
    if (clear_done_s) begin
      sx_d = {X_W{1'b0}};
      sy_d = {Y_W{1'b0}};
    end else if (rd_en_s) begin
      if (sx_q == X_LAST) begin
        sx_d = {X_W{1'b0}};
        if (sy_q == Y_LAST) sy_d = {Y_W{1'b0}};
        else                sy_d = sy_q + 1'b1;
      end else begin
        sx_d = sx_q + 1'b1;
        sy_d = sy_q;
      end
    end else begin
      sx_d = sx_q;
      sy_d = sy_q;
    end

    if (rd_en_s) begin
      scan_x_d = sx_q;
      scan_y_d = sy_q;
    end else begin
      scan_x_d = scan_x_q;
      scan_y_d = scan_y_q;
    end
  end

  assign busy        = fifo_full_s || (state_q == ST_CLEAR);
  assign overflow    = overflow_q;
  assign scan_x      = scan_x_q;
  assign scan_y      = scan_y_q;
  assign scan_colour = scan_colour_q;
  assign scan_valid  = scan_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Randomised bench for plot_framebuffer: a queue-level model of the plot FIFO and
// pixel store predicts every output; a monitor checks each cycle and each strobe.
module tb_plot_framebuffer;
  import plot_framebuffer_pkg::*;

  localparam int PD   = 2;
  localparam int NPIX = 160 * 120;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       plot_in, clear_in;
  logic       busy, overflow, scan_valid, frame_start;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [2:0] scan_colour;

  plot_framebuffer #(.FIFO_DEPTH(4), .PIX_DIV(PD)) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot_in(plot_in), .clear_in(clear_in), .busy(busy), .overflow(overflow),
    .scan_x(scan_x), .scan_y(scan_y), .scan_colour(scan_colour),
    .scan_valid(scan_valid), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int col;
  } wr_t;

  wr_t fq[$];
  wr_t exp_q[$];
  int  ref_mem [NPIX];
  int  tests = 0, fails = 0;
  int  cyc = 0, run_start = 0, clr_start = 0, epoch = 0;
  bit  clearing = 1'b0, ovf_m = 1'b0;
  int  strobes_f1 = 0, fs_f1 = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one clock interval per rising edge, from the plot/clear/scan rules.
  always @(posedge clock) begin : model_blk
    wr_t w;
    bit  tick, inr;
    int  n;
    if (!reset) begin
      fq.delete();
      ovf_m     = 1'b0;
      clearing  = 1'b0;
      run_start = cyc + 1;
    end else if (clear_in) begin
      if (clearing) ref_mem[cyc - clr_start] = 0;
      fq.delete();
      ovf_m     = 1'b0;
      clearing  = 1'b1;
      clr_start = cyc + 1;
    end else if (clearing) begin
      ref_mem[cyc - clr_start] = 0;
      if (cyc - clr_start == NPIX - 1) begin
        clearing  = 1'b0;
        run_start = cyc + 1;
        epoch++;
      end
    end else begin
      tick = ((cyc - run_start) % PD) == PD - 1;
      inr  = (x_in < 8'd160) && (y_in < 7'd120);
      n    = fq.size();
      if (n > 0 && !tick) begin
        w = fq.pop_front();
        ref_mem[w.idx] = w.col;
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].idx == w.idx) exp_q.delete(i);
        exp_q.push_back(w);
      end
      if (plot_in && inr) begin
        if (n < 4) begin
          w.idx = int'(y_in) * 160 + int'(x_in);
          w.col = int'(colour_in);
          fq.push_back(w);
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    cyc++;
  end

  // Monitor: compares outputs with the model mid-cycle; resolves probes on strobes.
  always @(negedge clock) begin : mon_blk
    int  rel, m, idx;
    bit  expv, found;
    if (!reset) begin
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_scan_valid", scan_valid, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_scan_x", scan_x, 0);
      check("rst_scan_y", scan_y, 0);
      check("rst_scan_colour", scan_colour, 0);
    end else begin
      check("busy", busy, int'(clearing || fq.size() == 4));
      check("overflow", overflow, int'(ovf_m));
      rel  = cyc - run_start;
      expv = !clearing && rel >= PD && (rel % PD) == 0;
      check("scan_valid", scan_valid, int'(expv));
      if (scan_valid && expv) begin
        m   = rel / PD - 1;
        idx = m % NPIX;
        check("scan_x", scan_x, idx % 160);
        check("scan_y", scan_y, idx / 160);
        check("frame_start", frame_start, int'(idx == 0));
        check("scan_colour", scan_colour, ref_mem[idx]);
        if (epoch == 1 && m < NPIX) begin
          strobes_f1++;
          if (frame_start) fs_f1++;
        end
        found = 1'b0;
        for (int i = 0; i < exp_q.size() && !found; i++) begin
          if (exp_q[i].idx == idx) begin
            check("probe_colour", scan_colour, exp_q[i].col);
            exp_q.delete(i);
            found = 1'b1;
          end
        end
      end else begin
        check("frame_start_idle", frame_start, 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic plot(input int x, input int y, input int c);
    x_in      = 8'(x);
    y_in      = 7'(y);
    colour_in = 3'(c);
    plot_in   = 1'b1;
    step();
    plot_in   = 1'b0;
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rs, t, guard;
    reset = 1'b0; plot_in = 1'b0; clear_in = 1'b0;
    x_in = 8'd0; y_in = 7'd0; colour_in = 3'd0;
    repeat (3) step();

    // Release reset and clear the whole store straight away.
    reset = 1'b1; clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    guard = 0;
    while (clearing && guard < NPIX + 100) begin
      step();
      guard++;
    end
    check("clear_done", int'(clearing), 0);
    rs = run_start;

    // Plot (7,2) so it lands in the cycle of the tick that reads (7,2).
    t = rs + PD - 1 + (2 * 160 + 7) * PD;
    wait_until(t - 1);
    plot(7, 2, 6);

    // Rows 0..9 are already scanned in this frame; plot there for the next frame.
    wait_until(rs + PD * 1610);
    plot(5, 3, 5);
    repeat (3) step();
    plot(160, 0, 7);
    plot(0, 120, 7);
    plot(255, 127, 3);
    repeat (6) step();
    check("no_overflow_out_of_range", overflow, 0);

    for (int i = 0; i < 24; i++) begin
      x_in      = 8'(4 * i + 1);
      y_in      = 7'd6;
      colour_in = 3'($urandom_range(1, 7));
      plot_in   = 1'b1;
      step();
    end
    plot_in = 1'b0;
    repeat (20) step();
    check("overflow_after_burst", overflow, 1);

    for (int i = 0; i < 30; i++) begin
      plot($urandom_range(0, 175), $urandom_range(0, 9), $urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) step();
    end

    wait_until(rs + PD * (NPIX + 1700));
    check("frame1_strobes", strobes_f1, NPIX);
    check("frame1_frame_starts", fs_f1, 1);
    check("probes_pending", exp_q.size(), 0);
    check("overflow_sticky", overflow, 1);

    // Second clear, interrupted by reset partway through.
    while (((cyc - run_start) % PD) != 0) step();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    repeat (1000) step();
    check("busy_mid_clear", busy, 1);
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (40 * PD) step();
    check("probes_pending_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plot_framebuffer.md
Name: plot_framebuffer

Overview:
- Sink end of the drawing-engine plot interface (x, y, colour, plotEn) produced by the board and win/lose drawers through the top-level mux.
- Buffers plot writes in a small FIFO and commits them to an internal 160x120x3 pixel store.
- Continuously scans the store out in raster order as a pixel stream for display or readback.
- Includes a full-screen clear sequencer, used on game restart.

Parameters:
- H_RES, 160, pixels per line; x range 0..H_RES-1.
- V_RES, 120, lines per frame; y range 0..V_RES-1.
- COLOUR_W, 3, bits per pixel.
- FIFO_DEPTH, 4, plot FIFO entries; must be a power of 2.
- PIX_DIV, 4, clocks per scanout pixel; must be at least 2.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- x_in  in  8  plot x coordinate.
- y_in  in  7  plot y coordinate.
- colour_in  in  COLOUR_W  plot colour.
- plot_in  in  1  plot request, one pixel per cycle when high.
- clear_in  in  1  synchronous request to clear the whole store to colour 0.
- busy  out  1  high when the FIFO is full or a clear is in progress.
- overflow  out  1  sticky flag: a valid in-range plot was dropped because the FIFO was full.
- scan_x  out  8  x of the current scanout pixel.
- scan_y  out  7  y of the current scanout pixel.
- scan_colour  out  COLOUR_W  stored colour at (scan_x, scan_y).
- scan_valid  out  1  one-cycle strobe; the scan_* outputs are valid in this cycle.
- frame_start  out  1  asserted together with scan_valid for pixel (0,0).

Behaviour:
- Reset (async, reset==0):
  - FIFO empty; overflow=0; busy=0.
  - scan_x=0, scan_y=0, scan_colour=0, scan_valid=0, frame_start=0.
  - Pixel divider loaded with PIX_DIV-1; FSM in RUN.
  - Store contents are not reset.
- Address arithmetic: addr = y*160 + x = (y<<7)+(y<<5)+x, 15 bits wide. No multiplier.
- Input acceptance:
  - A plot is enqueued when plot_in=1, FSM=RUN, x_in<H_RES, y_in<V_RES, and FIFO count<FIFO_DEPTH.
  - Out-of-range coordinates are silently discarded; overflow is not set.
  - In-range plot with FIFO full is dropped and sets overflow=1. overflow is cleared only by reset or clear_in.
  - A push is rejected when the FIFO is full, even if a pop occurs in the same cycle.
- Store port (single port, one access per clock):
  - The pixel divider counts down every cycle. When it reaches 0 ("tick") it reloads PIX_DIV-1.
  - On a tick, the scanout read has priority.
  - On non-tick cycles, the FIFO head is written to the store if the FIFO is not empty. Pop happens in the same cycle.
  - Plot-to-store latency is at least 2 cycles (enqueue, then write); further delay depends on queue depth and tick collisions.
- Scanout:
  - On a tick, the store is read at (sx, sy).
  - One cycle later: scan_valid=1; scan_x/scan_y = that coordinate; scan_colour = read data. frame_start=1 iff the coordinate is (0,0).
  - The counter advances x++ after each tick. When x=H_RES-1, x wraps to 0 and y increments. When y=V_RES-1, y wraps to 0.
  - A write and a read to the same address cannot share a cycle. A read issued after a committed write returns the new colour.
- FSM states:
  - RUN: normal operation as above.
  - CLEAR: entered when clear_in=1 in RUN, or when clear_in=1 during CLEAR, which restarts the sequence at address 0.
    - FIFO flushed on entry; overflow cleared; busy=1.
    - plot_in ignored; overflow is not set during CLEAR.
    - Scanout suspended: scan_valid=0.
    - Writes colour 0 to addr 0..19199, one per cycle, 19200 cycles.
    - After writing addr 19199: go to RUN; scan counter set to (0,0); divider reloaded.
- busy = (count==FIFO_DEPTH) or (state==CLEAR), combinational from registered state.
- Reset asserted mid-CLEAR or mid-frame: immediate return to the reset state. A partially cleared store is left as is.

Decomposition:
- Shared package holds: H_RES, V_RES, COLOUR_W, coordinate widths (8/7), address width (15), and the state encoding (RUN, CLEAR). The package is shared with the board and win/lose drawers.
- One natural sub-module, plot_fifo: a synchronous FIFO of {x, y, colour}.
  - Ports: push, pop, full, empty, head data.
  - Asynchronous active-low reset.
- The store is an inferred single-port RAM in the top block.

Test Plan:
- Reset, clear_in pulse, wait 19200+ cycles, then one full frame -> busy=1 throughout the clear; then 19200 scan_valid strobes, all with scan_colour=0; frame_start exactly once, at (0,0).
- Plot (5,3,colour 3'b101), then wait one frame -> the strobe with scan_x=5, scan_y=3 shows colour 101; all neighbours show 0.
- Plot x=160,y=0 and x=0,y=120 -> nothing enqueued; overflow stays 0; no store change.
- Hold plot_in high with distinct pixels every cycle, PIX_DIV=4 -> busy rises once 4 entries are pending; first dropped pixel sets overflow=1; every accepted pixel reads back correctly.
- Plot (0,0) in the cycle before a tick at (0,0) -> the read gets priority; the write commits next cycle; (0,0) shows the new colour on the following frame.
- Assert reset at clear address ~1000 -> all outputs return to reset values immediately; after release, scanout restarts at (0,0) with scan_valid cadence of PIX_DIV.
